// File: rtl/float_compare_pipe.sv
// rtl/float_compare_pipe.sv - parametrised IEEE-754 comparator with 2-stage valid/ready pipeline
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   a, b                operands, IEEE layout {sign, exp, man}
//   op                  0 LT, 1 LE, 2 EQ, 3 NE, 4 GT, 5 GE, 6 UNORD, 7 reserved
//   out_valid/out_ready result handshake (z, unordered, invalid)
//   z                   predicate result (a op b)
//   unordered           a or b is NaN
//   invalid             IEEE invalid-operation flag
module float_compare_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         z,
    output logic         unordered,
    output logic         invalid
);

    localparam logic [2:0] OP_LT    = 3'd0;
    localparam logic [2:0] OP_LE    = 3'd1;
    localparam logic [2:0] OP_EQ    = 3'd2;
    localparam logic [2:0] OP_NE    = 3'd3;
    localparam logic [2:0] OP_GT    = 3'd4;
    localparam logic [2:0] OP_GE    = 3'd5;
    localparam logic [2:0] OP_UNORD = 3'd6;

    localparam logic [W-1:0] SIGN_BIT = {1'b1, {(W-1){1'b0}}};

    // Stage 1 registers
    logic         s1_valid;
    logic [2:0]   s1_op;
    logic         s1_a_nan, s1_a_snan, s1_a_zero;
    logic         s1_b_nan, s1_b_snan, s1_b_zero;
    logic [W-1:0] s1_key_a, s1_key_b;

    // Stage 2 valid is the output valid
    logic s2_valid;
    logic s1_load, s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Operand classification
    logic         a_nan, a_snan, a_zero, b_nan, b_snan, b_zero;
    logic [W-1:0] key_a, key_b;

    always_comb begin
        a_nan  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
        a_snan = a_nan && !a[MAN_W-1];
        a_zero = ~|a[W-2:0];
        b_nan  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
        b_snan = b_nan && !b[MAN_W-1];
        b_zero = ~|b[W-2:0];
        // Sign-magnitude to monotonic unsigned: negatives invert, positives set the top bit.
        key_a  = a[W-1] ? ~a : (a | SIGN_BIT);
        key_b  = b[W-1] ? ~b : (b | SIGN_BIT);
    end

    // Stage 2 combinational decision
    logic cmp_lt, cmp_eq, nxt_unord, nxt_inv, nxt_z, ordering_op;

    always_comb begin
        cmp_lt      = s1_key_a < s1_key_b;
        cmp_eq      = s1_key_a == s1_key_b;
        // +0 and -0 map to different keys but must compare equal.
        if (s1_a_zero && s1_b_zero) begin
            cmp_lt = 1'b0;
            cmp_eq = 1'b1;
        end
        nxt_unord   = s1_a_nan || s1_b_nan;
        ordering_op = (s1_op == OP_LT) || (s1_op == OP_LE) ||
                      (s1_op == OP_GT) || (s1_op == OP_GE);
        nxt_inv     = s1_a_snan || s1_b_snan || (nxt_unord && ordering_op);
        nxt_z       = 1'b0;
        if (nxt_unord) begin
            nxt_z = (s1_op == OP_NE) || (s1_op == OP_UNORD);
        end else begin
            case (s1_op)
                OP_LT:   nxt_z = cmp_lt;
                OP_LE:   nxt_z = cmp_lt || cmp_eq;
                OP_EQ:   nxt_z = cmp_eq;
                OP_NE:   nxt_z = !cmp_eq;
                OP_GT:   nxt_z = !cmp_lt && !cmp_eq;
                OP_GE:   nxt_z = !cmp_lt;
                default: nxt_z = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a_nan  <= 1'b0;
            s1_a_snan <= 1'b0;
            s1_a_zero <= 1'b0;
            s1_b_nan  <= 1'b0;
            s1_b_snan <= 1'b0;
            s1_b_zero <= 1'b0;
            s1_key_a  <= '0;
            s1_key_b  <= '0;
            s2_valid  <= 1'b0;
            z         <= 1'b0;
            unordered <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op     <= op;
                    s1_a_nan  <= a_nan;
                    s1_a_snan <= a_snan;
                    s1_a_zero <= a_zero;
                    s1_b_nan  <= b_nan;
                    s1_b_snan <= b_snan;
                    s1_b_zero <= b_zero;
                    s1_key_a  <= key_a;
                    s1_key_b  <= key_b;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                // Outputs only move when a real result arrives, so they hold across bubbles.
                if (s1_valid) begin
                    z         <= nxt_z;
                    unordered <= nxt_unord;
                    invalid   <= nxt_inv;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_compare_pipe.sv
// tb/tb_float_compare_pipe.sv - scoreboard bench for float_compare_pipe (double precision)
module tb_float_compare_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic        z, unordered, invalid;

    float_compare_pipe #(.EXP_W(11), .MAN_W(52)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .unordered(unordered), .invalid(invalid)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ONE    = 64'h3FF0000000000000;
    localparam logic [63:0] TWO    = 64'h4000000000000000;
    localparam logic [63:0] NZERO  = 64'h8000000000000000;
    localparam logic [63:0] PZERO  = 64'h0000000000000000;
    localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN   = 64'h7FF0000000000001;
    localparam logic [63:0] PINF   = 64'h7FF0000000000000;
    localparam logic [63:0] NINF   = 64'hFFF0000000000000;
    localparam logic [63:0] NMAX   = 64'hFFEFFFFFFFFFFFFF;
    localparam logic [63:0] PDEN   = 64'h0000000000000001;
    localparam logic [63:0] NDEN   = 64'h8000000000000001;

    int n_total = 0;
    int n_pass  = 0;
    int n_sent  = 0;
    logic [2:0] q[$];          // expected {z, unordered, invalid}
    logic       saw_in_ready_low = 1'b0;
    logic       prev_stall = 1'b0;
    logic [2:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!in_ready) saw_in_ready_low = 1'b1;
            chk("in_ready_vs_occupancy", in_ready, !(q.size() == 2 && !out_ready));
            if (prev_stall && out_valid)
                chk("held_while_stalled", {z, unordered, invalid}, held);
            prev_stall = out_valid && !out_ready;
            held       = {z, unordered, invalid};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    logic [2:0] e;
                    e = q.pop_front();
                    chk("z", z, e[2]);
                    chk("unordered", unordered, e[1]);
                    chk("invalid", invalid, e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [63:0] va, input logic [63:0] vb,
                        input logic [2:0] vop, input logic [2:0] exp);
        int n = 0;
        a = va; b = vb; op = vop; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            @(posedge clk);
            q.push_back(exp);
            n_sent++;
            #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_unordered", unordered, 0);
        chk("rst_invalid", invalid, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();

        // 1) latency
        send(ONE, TWO, 3'd0, 3'b100);
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_out_valid", out_valid, 1);
        chk("lat_z", z, 1);
        drain();

        // 2) signed zeros
        send(NZERO, PZERO, 3'd2, 3'b100);
        send(NZERO, PZERO, 3'd0, 3'b000);
        send(NZERO, PZERO, 3'd5, 3'b100);
        // 3) quiet NaN
        send(QNAN, ONE, 3'd0, 3'b011);
        send(QNAN, ONE, 3'd3, 3'b110);
        send(QNAN, ONE, 3'd6, 3'b110);
        send(ONE, QNAN, 3'd5, 3'b011);
        // 4) signalling NaN
        send(SNAN, PINF, 3'd2, 3'b011);
        // 5) denormals and infinities
        send(PDEN, NDEN, 3'd4, 3'b100);
        send(NINF, NMAX, 3'd0, 3'b100);
        send(PINF, PINF, 3'd2, 3'b100);
        // reserved op
        send(SNAN, ONE, 3'd7, 3'b011);
        send(ONE, TWO, 3'd7, 3'b000);
        drain();

        // 6) streamed ops with a 4-cycle consumer stall
        base = n_sent;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [2:0] ez;
                    case (i)
                        0, 1, 3: ez = 3'b100;
                        default: ez = 3'b000;
                    endcase
                    send(ONE, TWO, i[2:0], ez);
                end
            end
            begin
                int n = 0;
                while (n_sent < base + 3 && n < 200) begin
                    @(posedge clk); #1;
                    n++;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_sent - base, 8);
        chk("in_ready_fell", saw_in_ready_low, 1);

        // reset mid-stream
        send(ONE, TWO, 3'd0, 3'b100);
        send(ONE, TWO, 3'd1, 3'b100);
        send(ONE, TWO, 3'd2, 3'b000);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale_result", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
